time_ctrl: RTL and testbench

Control FSM that sequences the min/sec/deci-second time counter. Turns single-cycle debounced key pulses into the counter's run/stop level, its 24-bit update bus and its one-cycle update trigger. Provides a set mode for editing minutes and seconds with a field-blink indicator and an inactivity timeout. Also drives the display mux: edit values while setting, live counter values otherwise.

---
 rtl/time_ctrl_if.sv | 30 +++
 rtl/time_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_time_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/time_ctrl_if.sv
// Key pulses, live counter values and the control/display outputs of time_ctrl.
interface time_ctrl_if;
  logic        key_start;
  logic        key_clr;
  logic        key_set;
  logic        key_add;
  logic [7:0]  cur_min;
  logic [7:0]  cur_sec;
  logic [7:0]  cur_deci_sec;
  logic        state;
  logic [23:0] update;
  logic        update_trigger;
  logic [1:0]  set_field;
  logic        blink;
  logic [7:0]  disp_min;
  logic [7:0]  disp_sec;
  logic [7:0]  disp_deci_sec;

  // Controller side
  modport master (
    input  key_start, key_clr, key_set, key_add, cur_min, cur_sec, cur_deci_sec,
    output state, update, update_trigger, set_field, blink, disp_min, disp_sec, disp_deci_sec
  );

  // Counter / keypad / display side
  modport slave (
    output key_start, key_clr, key_set, key_add, cur_min, cur_sec, cur_deci_sec,
    input  state, update, update_trigger, set_field, blink, disp_min, disp_sec, disp_deci_sec
  );
endinterface

// File: rtl/time_ctrl.sv
// Control FSM for the min/sec/deci-second counter: run/stop, clear, set mode with
// field blink and inactivity timeout, and a registered display mux.
module time_ctrl #(
  parameter int unsigned MIN_MAX     = 59,
  parameter int unsigned SEC_MAX     = 59,
  parameter int unsigned BLINK_CYC   = 25_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic         sclk,
  input  logic         nrst,
  time_ctrl_if.master  bus_io
);

  localparam int unsigned BlinkW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int unsigned ToW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYC - 1);
  localparam logic [ToW-1:0]    ToLast    = ToW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]        MinMax    = 8'(MIN_MAX);
  localparam logic [7:0]        SecMax    = 8'(SEC_MAX);

  typedef enum logic [1:0] {StStop, StRun, StSetMin, StSetSec} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [7:0]        edit_min_q, edit_min_d;
  logic [7:0]        edit_sec_q, edit_sec_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              state_q, state_d;
  logic [23:0]       update_q, update_d;
  logic              trig_q, trig_d;
  logic [1:0]        field_q, field_d;
  logic [7:0]        disp_min_q, disp_min_d;
  logic [7:0]        disp_sec_q, disp_sec_d;
  logic [7:0]        disp_deci_q, disp_deci_d;

  logic              k_clr, k_set, k_start, k_add, any_key;
  logic              in_set, next_in_set, load;
  logic [23:0]       load_val;

  // Key priority, FSM next state, edit registers, counters and output next values
  always_comb begin
    k_clr    = bus_io.key_clr;
    k_set    = !bus_io.key_clr && bus_io.key_set;
    k_start  = !bus_io.key_clr && !bus_io.key_set && bus_io.key_start;
    k_add    = !bus_io.key_clr && !bus_io.key_set && !bus_io.key_start && bus_io.key_add;
    any_key  = bus_io.key_clr | bus_io.key_set | bus_io.key_start | bus_io.key_add;
    in_set   = (fsm_q == StSetMin) || (fsm_q == StSetSec);

    fsm_d      = fsm_q;
    edit_min_d = edit_min_q;
    edit_sec_d = edit_sec_q;
    load       = 1'b0;
    load_val   = 24'd0;

    unique case (fsm_q)
      StStop: begin
        if (k_clr) begin
          load = 1'b1;
        end else if (k_set) begin
          fsm_d      = StSetMin;
          edit_min_d = bus_io.cur_min;
          edit_sec_d = bus_io.cur_sec;
        end else if (k_start) begin
          fsm_d = StRun;
        end
      end
      StRun: begin
        if (k_clr) begin
          fsm_d = StStop;
          load  = 1'b1;
        end else if (k_start) begin
          fsm_d = StStop;
        end
      end
      StSetMin: begin
        if (k_clr) begin
          fsm_d = StStop;
        end else if (k_set) begin
          fsm_d = StSetSec;
        end else if (k_add) begin
          edit_min_d = (edit_min_q >= MinMax) ? 8'd0 : edit_min_q + 8'd1;
        end else if (!any_key && to_cnt_q == ToLast) begin
          fsm_d = StStop;
        end
      end
      StSetSec: begin
        if (k_clr) begin
          fsm_d = StStop;
        end else if (k_set) begin
          fsm_d    = StStop;
          load     = 1'b1;
          load_val = {edit_min_q, edit_sec_q, 8'd0};
        end else if (k_add) begin
          edit_sec_d = (edit_sec_q >= SecMax) ? 8'd0 : edit_sec_q + 8'd1;
        end else if (!any_key && to_cnt_q == ToLast) begin
          fsm_d = StStop;
        end
      end
      default: fsm_d = StStop;
    endcase

    next_in_set = (fsm_d == StSetMin) || (fsm_d == StSetSec);

    // A strobe right after another is dropped so the trigger never stays high
    trig_d   = load && !trig_q;
    update_d = trig_d ? load_val : update_q;

    // Blink restarts on entry and after any edit so the field shows at once
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (next_in_set && in_set && !k_add && !k_set) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_d = !blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
      end
    end

    to_cnt_d = '0;
    if (next_in_set && !any_key) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    state_d = (fsm_d == StRun);
    field_d = (fsm_d == StSetMin) ? 2'd1 : ((fsm_d == StSetSec) ? 2'd2 : 2'd0);

    if (next_in_set) begin
      disp_min_d  = edit_min_d;
      disp_sec_d  = edit_sec_d;
      disp_deci_d = 8'd0;
    end else begin
      disp_min_d  = bus_io.cur_min;
      disp_sec_d  = bus_io.cur_sec;
      disp_deci_d = bus_io.cur_deci_sec;
    end
  end

  // State and registered outputs
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      fsm_q       <= StStop;
      edit_min_q  <= 8'd0;
      edit_sec_q  <= 8'd0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      to_cnt_q    <= '0;
      state_q     <= 1'b0;
      update_q    <= 24'd0;
      trig_q      <= 1'b0;
      field_q     <= 2'd0;
      disp_min_q  <= 8'd0;
      disp_sec_q  <= 8'd0;
      disp_deci_q <= 8'd0;
    end else begin
      fsm_q       <= fsm_d;
      edit_min_q  <= edit_min_d;
      edit_sec_q  <= edit_sec_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      to_cnt_q    <= to_cnt_d;
      state_q     <= state_d;
      update_q    <= update_d;
      trig_q      <= trig_d;
      field_q     <= field_d;
      disp_min_q  <= disp_min_d;
      disp_sec_q  <= disp_sec_d;
      disp_deci_q <= disp_deci_d;
    end
  end

  assign bus_io.state          = state_q;
  assign bus_io.update         = update_q;
  assign bus_io.update_trigger = trig_q;
  assign bus_io.set_field      = field_q;
  assign bus_io.blink          = blink_q;
  assign bus_io.disp_min       = disp_min_q;
  assign bus_io.disp_sec       = disp_sec_q;
  assign bus_io.disp_deci_sec  = disp_deci_q;

endmodule

// File: tb/tb_time_ctrl.sv
// Directed bench for time_ctrl with short blink and timeout periods.
module tb_time_ctrl;
  logic sclk;
  logic nrst;
  int   total;
  int   bad;

  time_ctrl_if tif ();

  time_ctrl #(
    .MIN_MAX    (59),
    .SEC_MAX    (59),
    .BLINK_CYC  (4),
    .TIMEOUT_CYC(20)
  ) dut (
    .sclk  (sclk),
    .nrst  (nrst),
    .bus_io(tif.master)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1);
  end

  // Pulse keys for one cycle; returns on the negedge after the sampling edge
  task automatic press(input logic clr, input logic set, input logic start, input logic add);
    @(negedge sclk);
    tif.key_clr   = clr;
    tif.key_set   = set;
    tif.key_start = start;
    tif.key_add   = add;
    @(negedge sclk);
    tif.key_clr   = 1'b0;
    tif.key_set   = 1'b0;
    tif.key_start = 1'b0;
    tif.key_add   = 1'b0;
  endtask

  task automatic set_cur(input logic [7:0] m, input logic [7:0] s, input logic [7:0] d);
    tif.cur_min      = m;
    tif.cur_sec      = s;
    tif.cur_deci_sec = d;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    repeat (2) @(negedge sclk);
    total++; if (tif.state !== 1'b0) begin bad++; $display("FAIL reset.state got=%0h exp=0", tif.state); end
    total++; if (tif.update !== 24'h0) begin bad++; $display("FAIL reset.update got=%h exp=000000", tif.update); end
    total++; if (tif.update_trigger !== 1'b0) begin bad++; $display("FAIL reset.trig got=%0h exp=0", tif.update_trigger); end
    total++; if (tif.set_field !== 2'd0) begin bad++; $display("FAIL reset.field got=%0d exp=0", tif.set_field); end
    total++; if (tif.blink !== 1'b0) begin bad++; $display("FAIL reset.blink got=%0h exp=0", tif.blink); end
    @(negedge sclk);
    nrst = 1'b1;
  endtask

  task automatic test_run_stop;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (tif.state !== 1'b1) begin bad++; $display("FAIL run_stop.run got=%0h exp=1", tif.state); end
    total++; if (tif.update_trigger !== 1'b0) begin bad++; $display("FAIL run_stop.trig1 got=%0h exp=0", tif.update_trigger); end
    press(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (tif.state !== 1'b0) begin bad++; $display("FAIL run_stop.stop got=%0h exp=0", tif.state); end
    total++; if (tif.update_trigger !== 1'b0) begin bad++; $display("FAIL run_stop.trig2 got=%0h exp=0", tif.update_trigger); end
  endtask

  task automatic test_edit_commit;
    set_cur(8'd58, 8'd10, 8'd4);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (tif.set_field !== 2'd1) begin bad++; $display("FAIL edit.field_min got=%0d exp=1", tif.set_field); end
    total++; if (tif.disp_min !== 8'd58) begin bad++; $display("FAIL edit.capture_min got=%0d exp=58", tif.disp_min); end
    total++; if (tif.disp_deci_sec !== 8'd0) begin bad++; $display("FAIL edit.disp_deci got=%0d exp=0", tif.disp_deci_sec); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (tif.disp_min !== 8'd59) begin bad++; $display("FAIL edit.min59 got=%0d exp=59", tif.disp_min); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (tif.disp_min !== 8'd0) begin bad++; $display("FAIL edit.min_wrap got=%0d exp=0", tif.disp_min); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (tif.set_field !== 2'd2) begin bad++; $display("FAIL edit.field_sec got=%0d exp=2", tif.set_field); end
    total++; if (tif.state !== 1'b0) begin bad++; $display("FAIL edit.state got=%0h exp=0", tif.state); end
    repeat (3) press(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (tif.disp_sec !== 8'd13) begin bad++; $display("FAIL edit.sec13 got=%0d exp=13", tif.disp_sec); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (tif.update !== 24'h000D00) begin bad++; $display("FAIL commit.update got=%h exp=000d00", tif.update); end
    total++; if (tif.update_trigger !== 1'b1) begin bad++; $display("FAIL commit.trig got=%0h exp=1", tif.update_trigger); end
    total++; if (tif.set_field !== 2'd0) begin bad++; $display("FAIL commit.field got=%0d exp=0", tif.set_field); end
    @(negedge sclk);
    total++; if (tif.update_trigger !== 1'b0) begin bad++; $display("FAIL commit.trig_drop got=%0h exp=0", tif.update_trigger); end
    total++; if (tif.update !== 24'h000D00) begin bad++; $display("FAIL commit.hold got=%h exp=000d00", tif.update); end
  endtask

  task automatic test_clear_run;
    set_cur(8'd3, 8'd25, 8'd7);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (tif.state !== 1'b1) begin bad++; $display("FAIL clear_run.run got=%0h exp=1", tif.state); end
    total++; if (tif.disp_min !== 8'd3) begin bad++; $display("FAIL clear_run.disp_min got=%0d exp=3", tif.disp_min); end
    total++; if (tif.disp_deci_sec !== 8'd7) begin bad++; $display("FAIL clear_run.disp_deci got=%0d exp=7", tif.disp_deci_sec); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (tif.state !== 1'b0) begin bad++; $display("FAIL clear_run.state got=%0h exp=0", tif.state); end
    total++; if (tif.update !== 24'h0) begin bad++; $display("FAIL clear_run.update got=%h exp=000000", tif.update); end
    total++; if (tif.update_trigger !== 1'b1) begin bad++; $display("FAIL clear_run.trig got=%0h exp=1", tif.update_trigger); end
    @(negedge sclk);
    total++; if (tif.update_trigger !== 1'b0) begin bad++; $display("FAIL clear_run.trig_drop got=%0h exp=0", tif.update_trigger); end
  endtask

  task automatic test_abort_timeout;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (tif.set_field !== 2'd0) begin bad++; $display("FAIL abort.field got=%0d exp=0", tif.set_field); end
    total++; if (tif.update_trigger !== 1'b0) begin bad++; $display("FAIL abort.trig got=%0h exp=0", tif.update_trigger); end
    // Idle timeout: entry edge plus 20 idle edges
    press(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (19) @(negedge sclk);
    total++; if (tif.set_field !== 2'd1) begin bad++; $display("FAIL timeout.before got=%0d exp=1", tif.set_field); end
    @(negedge sclk);
    total++; if (tif.set_field !== 2'd0) begin bad++; $display("FAIL timeout.abort got=%0d exp=0", tif.set_field); end
    total++; if (tif.update_trigger !== 1'b0) begin bad++; $display("FAIL timeout.trig got=%0h exp=0", tif.update_trigger); end
    // Key in the timeout cycle keeps set mode
    press(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (18) @(negedge sclk);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (tif.set_field !== 2'd1) begin bad++; $display("FAIL timeout.key_wins got=%0d exp=1", tif.set_field); end
    total++; if (tif.disp_min !== 8'd4) begin bad++; $display("FAIL timeout.key_add got=%0d exp=4", tif.disp_min); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_blink;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge sclk);
    total++; if (tif.blink !== 1'b0) begin bad++; $display("FAIL blink.phase0 got=%0h exp=0", tif.blink); end
    @(negedge sclk);
    total++; if (tif.blink !== 1'b1) begin bad++; $display("FAIL blink.toggle got=%0h exp=1", tif.blink); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (tif.blink !== 1'b0) begin bad++; $display("FAIL blink.add_restart got=%0h exp=0", tif.blink); end
    repeat (3) @(negedge sclk);
    total++; if (tif.blink !== 1'b0) begin bad++; $display("FAIL blink.restart_hold got=%0h exp=0", tif.blink); end
    @(negedge sclk);
    total++; if (tif.blink !== 1'b1) begin bad++; $display("FAIL blink.restart_toggle got=%0h exp=1", tif.blink); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (tif.blink !== 1'b0) begin bad++; $display("FAIL blink.stop got=%0h exp=0", tif.blink); end
  endtask

  task automatic test_simultaneous;
    // Commit 04:25.0 first so the clear has something to zero
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (tif.update !== 24'h041900) begin bad++; $display("FAIL simul.commit got=%h exp=041900", tif.update); end
    press(1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (tif.state !== 1'b0) begin bad++; $display("FAIL simul.state got=%0h exp=0", tif.state); end
    total++; if (tif.update_trigger !== 1'b1) begin bad++; $display("FAIL simul.trig got=%0h exp=1", tif.update_trigger); end
    total++; if (tif.update !== 24'h0) begin bad++; $display("FAIL simul.update got=%h exp=000000", tif.update); end
  endtask

  task automatic test_reset_mid_edit;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (tif.update !== 24'h031900) begin bad++; $display("FAIL rst_edit.commit got=%h exp=031900", tif.update); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (tif.set_field !== 2'd2) begin bad++; $display("FAIL rst_edit.in_sec got=%0d exp=2", tif.set_field); end
    nrst = 1'b0;
    #1;
    total++; if (tif.set_field !== 2'd0) begin bad++; $display("FAIL rst_edit.field got=%0d exp=0", tif.set_field); end
    total++; if (tif.update !== 24'h0) begin bad++; $display("FAIL rst_edit.update got=%h exp=000000", tif.update); end
    total++; if (tif.update_trigger !== 1'b0) begin bad++; $display("FAIL rst_edit.trig got=%0h exp=0", tif.update_trigger); end
    total++; if (tif.disp_sec !== 8'd0) begin bad++; $display("FAIL rst_edit.disp_sec got=%0d exp=0", tif.disp_sec); end
    @(negedge sclk);
    nrst = 1'b1;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (tif.state !== 1'b1) begin bad++; $display("FAIL rst_edit.start got=%0h exp=1", tif.state); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    tif.key_start = 1'b0;
    tif.key_clr   = 1'b0;
    tif.key_set   = 1'b0;
    tif.key_add   = 1'b0;
    set_cur(8'd0, 8'd0, 8'd0);
    test_reset;
    test_run_stop;
    test_edit_commit;
    test_clear_run;
    test_abort_timeout;
    test_blink;
    test_simultaneous;
    test_reset_mid_edit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
